// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl
// Command sequencer for the RPN calculator datapath. Turns KEY presses into
// stack commands (push, pop, binary op, clear) and drives an external
// synchronous register file and a combinational ALU. It keeps shadow copies of
// the top two stack entries for the displays.
//
// Ports:
//   clk2      clock, all state updates on posedge
//   rst       synchronous active-low reset
//   mode      ALU op select (00 add, 01 sub, 10 and, 11 or), latched per command
//   key       pushbuttons, active-low: [0] clear, [1] op, [2] pop, [3] push
//   val       switch value to push
//   rf_we / rf_waddr / rf_wdata   regfile write port
//   rf_raddr / rf_rdata           regfile read port (data one cycle after address)
//   alu_a / alu_b / alu_op / alu_y  ALU operands (next, top), op and result
//   top / next  shadows of rf[sp-1] / rf[sp-2], zero when not present
//   depth     stack pointer, 0..2^AW
//   counter   number of executed commands, wraps
//   busy      FSM not idle
//   err       sticky illegal-command flag, cleared by the next good command
module rpn_stack_ctrl #(
  parameter int AW = 4,
  parameter int W  = 16
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [3:0]    key,
  input  logic [W-1:0]  val,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic [AW-1:0] rf_raddr,
  input  logic [W-1:0]  rf_rdata,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_op,
  input  logic [W-1:0]  alu_y,
  output logic [W-1:0]  top,
  output logic [W-1:0]  next,
  output logic [AW:0]   depth,
  output logic [7:0]    counter,
  output logic          busy,
  output logic          err
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] TWO   = (AW+1)'(2);

  typedef enum logic [2:0] {IDLE, PUSH, POP, OP, CLR, RD, FILL} state_t;

  state_t        state, state_nx;
  logic [3:0]    key_sync, key_q, key_prev;
  logic [2:0]    warm;
  logic [3:0]    press;
  logic [AW:0]   sp, sp_dec, sp_m2;
  logic [W-1:0]  top_r, next_r;
  logic [7:0]    counter_r;
  logic          err_r;
  logic [1:0]    alu_op_r;
  logic [AW-1:0] raddr_hold;
  state_t        sel_state;
  logic          sel_legal;
  logic          accept;
  logic          done_ok;

  // The warm-up shift register marks when key_prev holds a real sample
  // rather than the reset value; until then no edge can be trusted, which
  // keeps a button held through reset from firing on release of rst.
  assign press  = key_prev & ~key_q & {4{warm[2]}};
  assign sp_dec = sp - ONE;
  assign sp_m2  = sp - TWO;
  assign accept = (state == IDLE) && (|press);

  // Pick the highest-priority press and decide whether it is legal for the
  // current depth.
  always_comb begin
    sel_state = IDLE;
    sel_legal = 1'b0;
    if (press[0]) begin
      sel_state = CLR;
      sel_legal = 1'b1;
    end else if (press[1]) begin
      sel_state = OP;
      sel_legal = (sp >= TWO);
    end else if (press[2]) begin
      sel_state = POP;
      sel_legal = (sp != '0);
    end else if (press[3]) begin
      sel_state = PUSH;
      sel_legal = (sp != DEPTH);
    end
  end

  // State register.
  always_ff @(posedge clk2) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and regfile port decode. The read address is driven
  // combinationally in RD so the synchronous regfile returns the entry
  // during FILL; otherwise it holds the last address issued.
  always_comb begin
    state_nx = state;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr = raddr_hold;
    done_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && sel_legal) state_nx = sel_state;
      end
      PUSH: begin
        rf_we    = 1'b1;
        rf_waddr = sp[AW-1:0];
        rf_wdata = val;
        state_nx = IDLE;
        done_ok  = 1'b1;
      end
      CLR: begin
        state_nx = IDLE;
        done_ok  = 1'b1;
      end
      POP: begin
        if (sp_dec >= TWO) state_nx = RD;
        else begin
          state_nx = IDLE;
          done_ok  = 1'b1;
        end
      end
      OP: begin
        rf_we    = 1'b1;
        rf_waddr = sp_m2[AW-1:0];
        rf_wdata = alu_y;
        if (sp_dec >= TWO) state_nx = RD;
        else begin
          state_nx = IDLE;
          done_ok  = 1'b1;
        end
      end
      RD: begin
        rf_raddr = sp_m2[AW-1:0];
        state_nx = FILL;
      end
      FILL: begin
        state_nx = IDLE;
        done_ok  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Key pipeline, stack shadows, depth, counter and error flag.
  always_ff @(posedge clk2) begin
    if (!rst) begin
      key_sync   <= 4'hF;
      key_q      <= 4'hF;
      key_prev   <= 4'hF;
      warm       <= '0;
      sp         <= '0;
      top_r      <= '0;
      next_r     <= '0;
      counter_r  <= '0;
      err_r      <= 1'b0;
      alu_op_r   <= '0;
      raddr_hold <= '0;
    end else begin
      key_sync <= key;
      key_q    <= key_sync;
      key_prev <= key_q;
      warm     <= {warm[1:0], 1'b1};
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_legal) alu_op_r <= mode;
            else           err_r    <= 1'b1;
          end
        end
        PUSH: begin
          next_r <= top_r;
          top_r  <= val;
          sp     <= sp + ONE;
        end
        CLR: begin
          sp     <= '0;
          top_r  <= '0;
          next_r <= '0;
        end
        POP: begin
          top_r <= next_r;
          sp    <= sp_dec;
          if (sp_dec < TWO) next_r <= '0;
        end
        OP: begin
          top_r <= alu_y;
          sp    <= sp_dec;
          if (sp_dec < TWO) next_r <= '0;
        end
        RD:   raddr_hold <= sp_m2[AW-1:0];
        FILL: next_r     <= rf_rdata;
        default: ;
      endcase
      if (done_ok) begin
        counter_r <= counter_r + 8'd1;
        err_r     <= 1'b0;
      end
    end
  end

  assign alu_a   = next_r;
  assign alu_b   = top_r;
  assign alu_op  = alu_op_r;
  assign top     = top_r;
  assign next    = next_r;
  assign depth   = sp;
  assign counter = counter_r;
  assign busy    = (state != IDLE);
  assign err     = err_r;

endmodule
